icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache.
- Sits between the instruction fetcher and the instruction port of the memory controller.
- Serves hits in one cycle from an internal tag/data array.
- On a miss it acts as the initiator on the memory controller's instruction interface: a level request with a stable address, held until a one-cycle done pulse. It then fills the line and returns the word.

Parameters:
- INDEX_BITS, 6: number of index bits; line count = 2^INDEX_BITS.
- ADDR_W, 32: address width; tag = addr[ADDR_W-1 : INDEX_BITS+2].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low = freeze all state.
- flush  in  1  fetch redirect; discard any outstanding response.
- fetch_req  in  1  fetcher requests an instruction.
- fetch_addr  in  32  byte address of the instruction; bits [1:0] ignored.
- fetch_valid  out  1  one-cycle pulse; fetch_ins is valid.
- fetch_ins  out  32  instruction word.
- mem_req  out  1  level request to the memory controller instruction port.
- mem_addr  out  32  word-aligned fill address; bits [1:0] always 0.
- mem_done  in  1  one-cycle pulse from the controller; mem_ins is valid in this cycle only.
- mem_ins  in  32  fill word; combinational from the controller, sampled only when mem_done=1.

Behaviour:
- Reset:
  - state=IDLE; all valid bits cleared; drop flag=0.
  - fetch_valid=0, fetch_ins=0, mem_req=0, mem_addr=0.
  - Reset in the middle of a fill aborts it. mem_req drops the next cycle; the controller handles the abort.
- rdy=0: every register holds its value; mem_done and mem_ins are ignored.
- Fetcher contract: fetch_req and fetch_addr stay stable until fetch_valid or flush is seen. fetch_req is sampled only in IDLE.
- IDLE, fetch_req=1, no flush:
  - Hit (valid[idx] and tag match): fetch_valid<=1 and fetch_ins<=data[idx] at the next edge. Latency is 1 cycle. State stays IDLE.
  - To avoid a double hit, a request is not re-accepted in the cycle fetch_valid is high.
  - Miss: mem_req<=1; mem_addr<={fetch_addr[31:2],2'b00}; state<=MISS; drop<=0.
- MISS:
  - mem_req and mem_addr are held constant.
  - flush=1 sets drop<=1; the fill is not aborted.
  - On mem_done=1 at an edge:
    - data[idx]<=mem_ins; tag[idx]<=tag; valid[idx]<=1.
    - mem_req<=0; state<=DONE.
    - fetch_ins<=mem_ins.
    - fetch_valid<=!(drop|flush).
- DONE:
  - Lasts exactly one cycle with mem_req=0, so the controller sees the request drop and resets its byte offset.
  - fetch_valid is cleared; state<=IDLE.
  - New requests are not accepted in DONE.
- flush in IDLE: fetch_valid<=0 next cycle; a fetch_req in the same cycle is ignored.
- Simultaneous mem_done and flush: the fill is written; no response is produced.
- fetch_valid is a single-cycle pulse in all paths.
- mem_done while not in MISS is ignored.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs stat_hits [31:0] and stat_misses [31:0].
  - Each increments by 1 on an accepted hit or miss decision in IDLE.
  - Flushed requests are not counted.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after rst, fetch_req=1, fetch_addr=0x00001004; controller asserts mem_done 5 cycles later with mem_ins=0x00A00093.
  - Required: mem_req=1, mem_addr=0x00001004 the cycle after the request. fetch_valid pulses once with fetch_ins=0x00A00093. mem_req is low for at least one cycle (DONE).
- Hit after fill:
  - Stimulus: repeat fetch of 0x00001004.
  - Required: fetch_valid=1 exactly one cycle after the request, fetch_ins=0x00A00093, mem_req stays 0.
- Conflict eviction (INDEX_BITS=6):
  - Stimulus: fetch 0x00001004, then 0x00001104 (same index, different tag), then 0x00001004.
  - Required: three misses; each mem_addr matches its request.
- Flush during miss:
  - Stimulus: miss on 0x00002000; flush=1 two cycles before mem_done (mem_ins=0x12345678).
  - Required: no fetch_valid. A following fetch of 0x00002000 hits in 1 cycle with 0x12345678.
- rdy stall and reset mid-fill:
  - Stimulus: rdy=0 for 3 cycles during MISS with mem_done=1 pulsed.
  - Required: pulse ignored, mem_req held.
  - Stimulus: rst asserted during MISS.
  - Required: mem_req=0 next cycle; all lines invalid afterwards.
- ICACHE_STATS_EN:
  - Stimulus: 1 miss then 3 hits on the same address.
  - Required: stat_misses=1, stat_hits=3.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and the memory controller.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_ins,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [31:0]       mem_ins
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, MISS, DONE} state_t;

    state_t                  state;
    logic                    drop;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];

    logic [INDEX_BITS-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]        req_tag, fill_tag;
    logic                    hit, accept;
    logic                    unused_addr_lsb;

    assign req_idx  = fetch_addr[INDEX_BITS+1:2];
    assign req_tag  = fetch_addr[ADDR_W-1:INDEX_BITS+2];
    // The fill target comes from the latched miss address; fetch_addr may move after a flush.
    assign fill_idx = mem_addr[INDEX_BITS+1:2];
    assign fill_tag = mem_addr[ADDR_W-1:INDEX_BITS+2];
    assign unused_addr_lsb = &{1'b0, fetch_addr[1:0]};

    assign hit    = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    // Blocking acceptance while fetch_valid is high keeps a still-asserted request from hitting twice.
    assign accept = (state == IDLE) && fetch_req && !flush && !fetch_valid;

    always_ff @(posedge clk) begin
        if (!rst && rdy && state == MISS && mem_done) begin
            data_mem[fill_idx] <= mem_ins;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            drop        <= 1'b0;
            valid       <= '0;
            fetch_valid <= 1'b0;
            fetch_ins   <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else if (rdy) begin
            fetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            fetch_valid <= 1'b1;
                            fetch_ins   <= data_mem[req_idx];
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {fetch_addr[ADDR_W-1:2], 2'b00};
                            drop     <= 1'b0;
                            state    <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (flush)
                        drop <= 1'b1;
                    if (mem_done) begin
                        valid[fill_idx] <= 1'b1;
                        mem_req         <= 1'b0;
                        fetch_ins       <= mem_ins;
                        fetch_valid     <= !(drop || flush);
                        state           <= DONE;
                    end
                end
                // One idle cycle with mem_req low lets the controller reset its fill state.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (rdy && accept) begin
            if (hit && stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 32'd1;
            if (!hit && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: expected fetch responses queued at issue, checked by a monitor.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, fetch_req, mem_done;
    logic [31:0] fetch_addr, mem_ins;
    logic        fetch_valid, mem_req;
    logic [31:0] fetch_ins, mem_addr;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];

    icache_direct #(.INDEX_BITS(6), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_ins(fetch_ins),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_ins(mem_ins)
`ifdef ICACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every fetch_valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (fetch_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got ins=%h, required no response", fetch_ins);
            end else begin
                e = exp_q.pop_front();
                if (fetch_ins !== e) begin
                    bad++;
                    $display("FAIL fetch_ins: got %h, required %h", fetch_ins, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic miss_fetch(input logic [31:0] addr, input logic [31:0] ins, input int lat);
        fetch_addr = addr;
        fetch_req  = 1'b1;
        tick;
        check("miss_mem_req", {31'd0, mem_req}, 32'd1);
        check("miss_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        exp_q.push_back(ins);
        repeat (lat - 1) tick;
        check("miss_req_held", {31'd0, mem_req}, 32'd1);
        mem_done = 1'b1;
        mem_ins  = ins;
        tick;
        mem_done  = 1'b0;
        mem_ins   = 32'h0;
        fetch_req = 1'b0;
        check("done_mem_req_low", {31'd0, mem_req}, 32'd0);
        tick;
        check("valid_single_pulse", {31'd0, fetch_valid}, 32'd0);
    endtask

    task automatic hit_fetch(input logic [31:0] addr, input logic [31:0] ins);
        fetch_addr = addr;
        fetch_req  = 1'b1;
        exp_q.push_back(ins);
        tick;
        check("hit_latency", {31'd0, fetch_valid}, 32'd1);
        check("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
        fetch_req = 1'b0;
        tick;
        check("hit_single_pulse", {31'd0, fetch_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; fetch_req = 1'b0; mem_done = 1'b0;
        fetch_addr = 32'h0; mem_ins = 32'h0;
        tick; tick;
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_ins", fetch_ins, 32'h0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_stat_hits", stat_hits, 32'd0);
        check("rst_stat_misses", stat_misses, 32'd0);
`endif
        rst = 1'b0;

        // Cold miss then hits, including ignored byte-offset bits.
        miss_fetch(32'h0000_1004, 32'h00A0_0093, 5);
        hit_fetch(32'h0000_1004, 32'h00A0_0093);
        hit_fetch(32'h0000_1006, 32'h00A0_0093);

        // Flush in IDLE swallows a same-cycle request.
        fetch_addr = 32'h0000_1004; fetch_req = 1'b1; flush = 1'b1;
        tick;
        fetch_req = 1'b0; flush = 1'b0;
        check("idle_flush_no_valid", {31'd0, fetch_valid}, 32'd0);
        check("idle_flush_no_req", {31'd0, mem_req}, 32'd0);

        // Stray mem_done in IDLE must not corrupt anything.
        mem_done = 1'b1; mem_ins = 32'h0BAD_0BAD;
        tick;
        mem_done = 1'b0; mem_ins = 32'h0;
        check("idle_done_no_req", {31'd0, mem_req}, 32'd0);
        hit_fetch(32'h0000_1004, 32'h00A0_0093);

        // Flush two cycles before mem_done: fill lands, no response.
        fetch_addr = 32'h0000_2000; fetch_req = 1'b1;
        tick;
        check("flush_miss_req", {31'd0, mem_req}, 32'd1);
        check("flush_miss_addr", mem_addr, 32'h0000_2000);
        flush = 1'b1; fetch_req = 1'b0;
        tick;
        flush = 1'b0;
        tick;
        mem_done = 1'b1; mem_ins = 32'h1234_5678;
        tick;
        mem_done = 1'b0; mem_ins = 32'h0;
        check("flush_done_req_low", {31'd0, mem_req}, 32'd0);
        tick;
        hit_fetch(32'h0000_2000, 32'h1234_5678);

        // mem_done together with flush: fill written (evicting 0x2000), no response.
        fetch_addr = 32'h0000_2100; fetch_req = 1'b1;
        tick;
        check("simul_miss_addr", mem_addr, 32'h0000_2100);
        mem_done = 1'b1; flush = 1'b1; fetch_req = 1'b0; mem_ins = 32'hCAFE_F00D;
        tick;
        mem_done = 1'b0; flush = 1'b0; mem_ins = 32'h0;
        tick;
        hit_fetch(32'h0000_2100, 32'hCAFE_F00D);

        // rdy low freezes the miss and ignores mem_done; then reset aborts the fill.
        fetch_addr = 32'h0000_3008; fetch_req = 1'b1;
        tick;
        check("stall_miss_req", {31'd0, mem_req}, 32'd1);
        rdy = 1'b0; mem_done = 1'b1; mem_ins = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_req_held", {31'd0, mem_req}, 32'd1);
            check("stall_addr_held", mem_addr, 32'h0000_3008);
        end
        rdy = 1'b1; mem_done = 1'b0; mem_ins = 32'h0;
        tick;
        check("stall_still_miss", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; fetch_req = 1'b0;
        tick;
        rst = 1'b0;
        check("midfill_rst_req", {31'd0, mem_req}, 32'd0);
        check("midfill_rst_addr", mem_addr, 32'h0);

        // After reset everything misses; 0x1004/0x1104 conflict on index 1.
        miss_fetch(32'h0000_1004, 32'h00A0_0093, 3);
        miss_fetch(32'h0000_1104, 32'h1111_1111, 2);
        miss_fetch(32'h0000_1004, 32'h00A0_0093, 2);
        miss_fetch(32'h0000_3008, 32'h3333_3333, 1);
        hit_fetch(32'h0000_3008, 32'h3333_3333);

        // Counter scenario: one miss then three hits from a clean reset.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        miss_fetch(32'h0000_4000, 32'h0040_0013, 2);
        for (int i = 0; i < 3; i++) hit_fetch(32'h0000_4000, 32'h0040_0013);
`ifdef ICACHE_STATS_EN
        check("stat_misses", stat_misses, 32'd1);
        check("stat_hits", stat_hits, 32'd3);
`endif

        tick; tick;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
